// File: rtl/ps_sobel_pkg.sv
// Shared types and default geometry for the ps_sobel gradient block.
// Optional feature macro PS_SOBEL_THRESH_EN is handled in ps_sobel_if and ps_sobel.
package ps_pkg;

  localparam int DATA_W  = 8;
  localparam int LINE_W  = 640;
  localparam int FRAME_H = 480;

  typedef logic [DATA_W-1:0]   pixel_t;
  typedef logic [3*DATA_W-1:0] window_row_t;
  typedef logic [9:0]          grad_t;

  // Columns are packed left-to-right from the MSB end: col 0 = [23:16].
  function automatic pixel_t pixAt(input window_row_t row, input int col);
    return row[(2-col)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/ps_sobel_if.sv
// Window-in / pixel-out bundle for ps_sobel.
// PS_SOBEL_THRESH_EN adds the i_thresh input for binary edge-map output.
interface ps_sobel_if import ps_pkg::*; ();

  window_row_t i_r0_data;
  window_row_t i_r1_data;
  window_row_t i_r2_data;
  logic        i_valid;
`ifdef PS_SOBEL_THRESH_EN
  pixel_t      i_thresh;
`endif
  pixel_t      o_data;
  logic        o_valid;
  logic        o_sol;
  logic        o_eol;
  logic        o_sof;
  logic        o_eof;

`ifdef PS_SOBEL_THRESH_EN
  modport master (output i_r0_data, i_r1_data, i_r2_data, i_valid, i_thresh,
                  input  o_data, o_valid, o_sol, o_eol, o_sof, o_eof);
  modport slave  (input  i_r0_data, i_r1_data, i_r2_data, i_valid, i_thresh,
                  output o_data, o_valid, o_sol, o_eol, o_sof, o_eof);
`else
  modport master (output i_r0_data, i_r1_data, i_r2_data, i_valid,
                  input  o_data, o_valid, o_sol, o_eol, o_sof, o_eof);
  modport slave  (input  i_r0_data, i_r1_data, i_r2_data, i_valid,
                  output o_data, o_valid, o_sol, o_eol, o_sof, o_eof);
`endif

endinterface

// File: rtl/ps_sobel_axis.sv
// One Sobel axis: weighted sums (stage 1) then absolute difference (stage 2).
module ps_sobel_axis import ps_pkg::*; (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_load1,
  input  logic   i_load2,
  input  pixel_t i_pos_a,
  input  pixel_t i_pos_b,
  input  pixel_t i_pos_c,
  input  pixel_t i_neg_a,
  input  pixel_t i_neg_b,
  input  pixel_t i_neg_c,
  output grad_t  o_abs
);

  grad_t sumPos_d, sumNeg_d, absDiff_d;
  grad_t sumPos_q, sumNeg_q, absDiff_q;

  // Centre tap carries weight 2; max sum 4*255 = 1020 fits in 10 bits.
  always_comb begin
    sumPos_d  = {2'b00, i_pos_a} + {1'b0, i_pos_b, 1'b0} + {2'b00, i_pos_c};
    sumNeg_d  = {2'b00, i_neg_a} + {1'b0, i_neg_b, 1'b0} + {2'b00, i_neg_c};
    absDiff_d = (sumPos_q >= sumNeg_q) ? (sumPos_q - sumNeg_q) : (sumNeg_q - sumPos_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sumPos_q  <= '0;
      sumNeg_q  <= '0;
      absDiff_q <= '0;
    end else begin
      if (i_load1) begin
        sumPos_q <= sumPos_d;
        sumNeg_q <= sumNeg_d;
      end
      if (i_load2) begin
        absDiff_q <= absDiff_d;
      end
    end
  end

  assign o_abs = absDiff_q;

endmodule

// File: rtl/ps_sobel.sv
// Sobel |Gx|+|Gy| magnitude, 3-cycle pipeline, with line/frame position flags.
// Define PS_SOBEL_THRESH_EN to output a binary edge map against i_thresh instead.
module ps_sobel #(
  parameter int LINE_W  = ps_pkg::LINE_W,
  parameter int FRAME_H = ps_pkg::FRAME_H
) (
  input logic       i_clk,
  input logic       i_rst,
  ps_sobel_if.slave bus
);
  import ps_pkg::*;

  localparam int COL_W = (LINE_W  > 1) ? $clog2(LINE_W)  : 1;
  localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_H - 1);

  grad_t            absX, absY;
  logic             valid1_q, valid2_q, valid3_q;
  logic [10:0]      mag;
  pixel_t           data_d, data_q;
  logic             sol_q, eol_q, sof_q, eof_q;
  logic             lastCol, lastRow;
  logic [COL_W-1:0] colCnt_d, colCnt_q;
  logic [ROW_W-1:0] rowCnt_d, rowCnt_q;
  logic             unusedCentre;

  // The centre pixel has zero weight in both kernels.
  assign unusedCentre = ^pixAt(bus.i_r1_data, 1);

  ps_sobel_axis axisX (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load1 (bus.i_valid),
    .i_load2 (valid1_q),
    .i_pos_a (pixAt(bus.i_r0_data, 2)),
    .i_pos_b (pixAt(bus.i_r1_data, 2)),
    .i_pos_c (pixAt(bus.i_r2_data, 2)),
    .i_neg_a (pixAt(bus.i_r0_data, 0)),
    .i_neg_b (pixAt(bus.i_r1_data, 0)),
    .i_neg_c (pixAt(bus.i_r2_data, 0)),
    .o_abs   (absX)
  );

  ps_sobel_axis axisY (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load1 (bus.i_valid),
    .i_load2 (valid1_q),
    .i_pos_a (pixAt(bus.i_r2_data, 0)),
    .i_pos_b (pixAt(bus.i_r2_data, 1)),
    .i_pos_c (pixAt(bus.i_r2_data, 2)),
    .i_neg_a (pixAt(bus.i_r0_data, 0)),
    .i_neg_b (pixAt(bus.i_r0_data, 1)),
    .i_neg_c (pixAt(bus.i_r0_data, 2)),
    .o_abs   (absY)
  );

  // Counters step as each pixel enters the output register so back-to-back pixels see fresh positions.
  always_comb begin
    mag      = {1'b0, absX} + {1'b0, absY};
`ifdef PS_SOBEL_THRESH_EN
    data_d   = (mag >= {3'b000, bus.i_thresh}) ? 8'hFF : 8'h00;
`else
    data_d   = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif
    lastCol  = (colCnt_q == LAST_COL);
    lastRow  = (rowCnt_q == LAST_ROW);
    colCnt_d = colCnt_q;
    rowCnt_d = rowCnt_q;
    if (valid2_q) begin
      if (lastCol) begin
        colCnt_d = '0;
        rowCnt_d = lastRow ? '0 : rowCnt_q + 1'b1;
      end else begin
        colCnt_d = colCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      valid3_q <= 1'b0;
      data_q   <= '0;
      sol_q    <= 1'b0;
      eol_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      colCnt_q <= '0;
      rowCnt_q <= '0;
    end else begin
      valid1_q <= bus.i_valid;
      valid2_q <= valid1_q;
      valid3_q <= valid2_q;
      if (valid2_q) begin
        data_q <= data_d;
      end
      sol_q    <= valid2_q && (colCnt_q == '0);
      eol_q    <= valid2_q && lastCol;
      sof_q    <= valid2_q && (colCnt_q == '0) && (rowCnt_q == '0);
      eof_q    <= valid2_q && lastCol && lastRow;
      colCnt_q <= colCnt_d;
      rowCnt_q <= rowCnt_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid3_q;
  assign bus.o_sol   = sol_q;
  assign bus.o_eol   = eol_q;
  assign bus.o_sof   = sof_q;
  assign bus.o_eof   = eof_q;

endmodule

// File: tb/tb_ps_sobel.sv
// Self-checking bench for ps_sobel: directed cases, random windows, framing and mid-frame reset.
// Honors PS_SOBEL_THRESH_EN the same way as the design.
module tb_ps_sobel;
  import ps_pkg::*;

  localparam int TB_LINE_W  = 16;
  localparam int TB_FRAME_H = 6;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic [3:0] flags;   // {sol, eol, sof, eof}
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps_sobel_if bus ();

  ps_sobel #(.LINE_W(TB_LINE_W), .FRAME_H(TB_FRAME_H)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  exp_t expQ[$];
  int   cycle = 0;
  int   pixIdx = 0;
  int   total = 0;
  int   bad = 0;
  int   solCnt = 0, eolCnt = 0, sofCnt = 0, eofCnt = 0;
`ifdef PS_SOBEL_THRESH_EN
  logic [7:0] tbThresh = 8'h40;
`endif

  // Sobel magnitude straight from the kernel definition, using signed integer arithmetic.
  function automatic logic [7:0] refPixel(input logic [23:0] r0, input logic [23:0] r1,
                                          input logic [23:0] r2);
    int p [3][3];
    logic [23:0] rows [3];
    int gx, gy, m;
    rows[0] = r0; rows[1] = r1; rows[2] = r2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = int'((rows[r] >> ((2 - c) * 8)) & 24'hFF);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef PS_SOBEL_THRESH_EN
    return (m >= int'(tbThresh)) ? 8'hFF : 8'h00;
`else
    return (m > 255) ? 8'hFF : 8'(m);
`endif
  endfunction

  task automatic checkOutput();
    exp_t e;
    logic expV;
    expV = (expQ.size() > 0) && (expQ[0].due == cycle);
    total++;
    assert (bus.o_valid === expV) else begin
      bad++;
      $error("[TB] FAIL valid cyc=%0d got=%b want=%b", cycle, bus.o_valid, expV);
    end
    if (expV) begin
      e = expQ.pop_front();
      total++;
      assert (bus.o_data === e.data) else begin
        bad++;
        $error("[TB] FAIL data cyc=%0d got=%h want=%h", cycle, bus.o_data, e.data);
      end
      total++;
      assert ({bus.o_sol, bus.o_eol, bus.o_sof, bus.o_eof} === e.flags) else begin
        bad++;
        $error("[TB] FAIL flags cyc=%0d got=%b want=%b", cycle,
               {bus.o_sol, bus.o_eol, bus.o_sof, bus.o_eof}, e.flags);
      end
    end else begin
      total++;
      assert ({bus.o_sol, bus.o_eol, bus.o_sof, bus.o_eof} === 4'b0000) else begin
        bad++;
        $error("[TB] FAIL idleflags cyc=%0d got=%b want=0000", cycle,
               {bus.o_sol, bus.o_eol, bus.o_sof, bus.o_eof});
      end
    end
    if (bus.o_valid === 1'b1) begin
      solCnt += int'(bus.o_sol);
      eolCnt += int'(bus.o_eol);
      sofCnt += int'(bus.o_sof);
      eofCnt += int'(bus.o_eof);
    end
  endtask

  // One cycle: check what is on the outputs now, then present the next window.
  task automatic applyStimulus(input logic v, input logic [23:0] r0, input logic [23:0] r1,
                               input logic [23:0] r2, input logic useConst,
                               input logic [7:0] constData);
    exp_t e;
    int   col, row;
    @(negedge clk);
    cycle++;
    checkOutput();
    bus.i_valid   = v;
    bus.i_r0_data = r0;
    bus.i_r1_data = r1;
    bus.i_r2_data = r2;
    if (v) begin
      col     = pixIdx % TB_LINE_W;
      row     = (pixIdx / TB_LINE_W) % TB_FRAME_H;
      e.due   = cycle + 3;
      e.data  = useConst ? constData : refPixel(r0, r1, r2);
      e.flags = {col == 0, col == TB_LINE_W - 1,
                 col == 0 && row == 0, col == TB_LINE_W - 1 && row == TB_FRAME_H - 1};
      expQ.push_back(e);
      pixIdx++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 24'h0, 24'h0, 24'h0, 1'b0, 8'h00);
  endtask

  task automatic randomWindows(input int n);
    int sent = 0;
    while (sent < n) begin
      if ($urandom_range(0, 3) != 0) begin
        applyStimulus(1'b1, 24'($urandom()), 24'($urandom()), 24'($urandom()), 1'b0, 8'h00);
        sent++;
      end else begin
        applyStimulus(1'b0, 24'($urandom()), 24'($urandom()), 24'($urandom()), 1'b0, 8'h00);
      end
    end
  endtask

  task automatic drain();
    int budget = 20;
    while (expQ.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    total++;
    assert (expQ.size() == 0) else begin
      bad++;
      $error("[TB] FAIL drain pending=%0d want=0", expQ.size());
    end
  endtask

  // Asynchronous reset landing between edges; in-flight pixels must vanish at once.
  task automatic doReset();
    @(negedge clk);
    cycle++;
    checkOutput();
    bus.i_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++;
    assert ({bus.o_valid, bus.o_sol, bus.o_eol, bus.o_sof, bus.o_eof} === 5'b00000) else begin
      bad++;
      $error("[TB] FAIL rstnow got=%b want=00000",
             {bus.o_valid, bus.o_sol, bus.o_eol, bus.o_sof, bus.o_eof});
    end
    expQ.delete();
    pixIdx = 0;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_valid   = 1'b0;
    bus.i_r0_data = '0;
    bus.i_r1_data = '0;
    bus.i_r2_data = '0;
`ifdef PS_SOBEL_THRESH_EN
    bus.i_thresh  = tbThresh;
`endif
    idle(3);
    rst = 1'b0;
    idle(2);

    $display("[TB] directed cases");
`ifdef PS_SOBEL_THRESH_EN
    applyStimulus(1'b1, 24'h808080, 24'h808080, 24'h808080, 1'b1, 8'h00);
    idle(4);
    applyStimulus(1'b1, 24'h101020, 24'h101020, 24'h101020, 1'b1, 8'hFF);
    applyStimulus(1'b1, 24'h101010, 24'h101010, 24'h181818, 1'b1, 8'h00);
`else
    applyStimulus(1'b1, 24'h808080, 24'h808080, 24'h808080, 1'b1, 8'h00);
    idle(4);
    applyStimulus(1'b1, 24'h101020, 24'h101020, 24'h101020, 1'b1, 8'h40);
    applyStimulus(1'b1, 24'h101010, 24'h101010, 24'h181818, 1'b1, 8'h20);
`endif
    applyStimulus(1'b1, 24'h000000, 24'h000000, 24'hFFFFFF, 1'b1, 8'hFF);
    applyStimulus(1'b1, 24'h000000, 24'h000000, 24'h404040, 1'b1, 8'hFF);
    drain();

    $display("[TB] random windows with gaps");
    randomWindows(40);
    drain();
`ifdef PS_SOBEL_THRESH_EN
    tbThresh     = 8'h00;
    bus.i_thresh = tbThresh;
    randomWindows(12);
    drain();
    tbThresh     = 8'h40;
    bus.i_thresh = tbThresh;
`endif

    $display("[TB] mid-frame reset");
    applyStimulus(1'b1, 24'($urandom()), 24'($urandom()), 24'($urandom()), 1'b0, 8'h00);
    applyStimulus(1'b1, 24'($urandom()), 24'($urandom()), 24'($urandom()), 1'b0, 8'h00);
    applyStimulus(1'b1, 24'($urandom()), 24'($urandom()), 24'($urandom()), 1'b0, 8'h00);
    doReset();
    randomWindows(3);
    drain();

    $display("[TB] two full frames");
    doReset();
    solCnt = 0; eolCnt = 0; sofCnt = 0; eofCnt = 0;
    randomWindows(2 * TB_LINE_W * TB_FRAME_H);
    drain();
    total++;
    assert (solCnt == 2 * TB_FRAME_H) else begin
      bad++; $error("[TB] FAIL solCount got=%0d want=%0d", solCnt, 2 * TB_FRAME_H);
    end
    total++;
    assert (eolCnt == 2 * TB_FRAME_H) else begin
      bad++; $error("[TB] FAIL eolCount got=%0d want=%0d", eolCnt, 2 * TB_FRAME_H);
    end
    total++;
    assert (sofCnt == 2) else begin
      bad++; $error("[TB] FAIL sofCount got=%0d want=2", sofCnt);
    end
    total++;
    assert (eofCnt == 2) else begin
      bad++; $error("[TB] FAIL eofCount got=%0d want=2", eofCnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
